abacus_dump_master: RTL and testbench
=====================================

# abacus_dump_master

Wishbone classic initiator that reads a contiguous window of ABACUS profiler counter registers and forwards each word on a valid/ready output stream, for example to a UART transmitter or a trace buffer. It is the initiator for the ABACUS Wishbone responder. It sits between the ABACUS register slave and the host-side export path. It can optionally clear the counters after a dump by toggling a profiler enable register.

## Interface
- ABACUS_BASE_ADDR, 32'hf0030000, base address of the ABACUS register block.
- FIRST_OFFSET, 32'h0000000C, byte offset of the first counter to read.
- NUM_WORDS, 11, number of 32-bit words per dump; must be 1..255 (elaboration error otherwise).
- CLEAR_AFTER_DUMP, 1'b0, when 1, writes 0 then 1 to CTRL_OFFSET after the last word.
- CTRL_OFFSET, 32'h00000004, byte offset of the profiler enable register used for clearing.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ack (used only with the timeout macro).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a dump completes or aborts.
- err  out  1  one-cycle pulse, coincident with done, on timeout abort.
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone classic master controls.
- wb_adr  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack  in  1  responder acknowledge.
- m_data  out  32  captured counter value.
- m_index  out  8  word index 0..NUM_WORDS-1.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states: IDLE, RD_REQ, PUSH, CLR_OFF, CLR_ON, FINISH.
- IDLE -> RD_REQ on start. Clears the index; busy goes high.
- RD_REQ:
  - cyc=stb=1, we=0.
  - wb_adr = ABACUS_BASE_ADDR + FIRST_OFFSET + 4*index, modulo 2^32.
  - On wb_ack: capture wb_dat_i into m_data, drop cyc/stb on the next edge, then go to PUSH.
- PUSH:
  - m_valid=1; m_data and m_index are held stable until m_ready.
  - On a valid&ready handshake, if index==NUM_WORDS-1, go to CLR_OFF when CLEAR_AFTER_DUMP is set, otherwise FINISH.
  - Otherwise increment index and go to RD_REQ.
  - No bus cycle is issued while PUSH is stalled.
- CLR_OFF: write wb_dat_o=0 to base+CTRL_OFFSET with we=1; on ack, go to CLR_ON.
- CLR_ON: write wb_dat_o=1 to the same address; on ack, go to FINISH.
- FINISH: pulse done for one cycle, drop busy, return to IDLE.
- Boundary conditions:
  - start while busy is ignored.
  - wb_ack while stb is low is ignored.
  - m_ready while m_valid is low has no effect.
  - wb_dat_o is 0 during reads.
- Reset asserted mid-transfer forces IDLE asynchronously and clears cyc, stb, m_valid and index. A partial dump is discarded with no done pulse.

## Timing
- start at edge N: cyc/stb are high after edge N+1.
- With a combinational-ack responder, each read costs 2 cycles (request, release) plus at least 1 PUSH cycle.
- Ack sampled at edge K: cyc/stb are low and m_valid is high after edge K.
- Back-to-back bus cycles are always separated by at least one idle cycle (cyc low).
- done asserts exactly one cycle after the final handshake or final clear ack.

## Configuration
- ABACUS_DUMP_TIMEOUT_EN defined:
  - A wait counter runs in RD_REQ, CLR_OFF and CLR_ON.
  - When it reaches TIMEOUT_CYCLES without ack, cyc/stb drop, done and err pulse together, and the FSM returns to IDLE.
  - Remaining words are not read and no clear is performed.
  - The counter resets on every new bus cycle.
- Undefined: the master waits for ack indefinitely, and err is tied to 0.

## Structure
- abacus_pkg: the FSM state enum and the register offset constants (enable at 0x04, cache enable at 0x08, first counter at 0x0C).
- Optional sub-module abacus_wb_timeout: loadable down-counter with an expired flag. It is instantiated only under ABACUS_DUMP_TIMEOUT_EN.

## Test plan
- Single-cycle ack responder, NUM_WORDS=3, m_ready=1 → reads addresses f003000C, f0030010, f0030014; stream indices 0,1,2 carry the responder values; one done pulse; no err.
- m_ready held low for 20 cycles at index 1 → m_valid and m_data stay stable, cyc stays 0, and the dump resumes on release.
- CLEAR_AFTER_DUMP=1 → after the last word, a write of 0 then 1 to f0030004, each with we=1, then done.
- Timeout macro on, TIMEOUT_CYCLES=8, responder never acks index 0 → cyc drops after 8 cycles; done and err pulse together; m_valid never rises.
- start pulsed again while busy, plus a stray ack while cyc is low → no extra transfers and the word count is unchanged.
- rst driven low during RD_REQ → cyc, stb, m_valid and busy are 0 immediately; a later start runs a clean full dump from index 0.

Source files
------------

// File: rtl/abacus_pkg.sv
// Shared definitions for the ABACUS dump master: FSM states, register offsets
// and the counter address helper.
package abacus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_PUSH,
        ST_CLR_OFF,
        ST_CLR_ON,
        ST_FINISH
    } dump_state_e;

    localparam logic [31:0] ABACUS_OFS_ENABLE    = 32'h0000_0004;
    localparam logic [31:0] ABACUS_OFS_CACHE_EN  = 32'h0000_0008;
    localparam logic [31:0] ABACUS_OFS_FIRST_CNT = 32'h0000_000C;

    // Byte address of counter word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] ofs,
                                              input logic [7:0]  idx);
        return base + ofs + {22'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/abacus_wb_timeout.sv
// Loadable down-counter bounding how long a Wishbone cycle may wait for ack.
// Expired once the count has run down to zero.
module abacus_wb_timeout #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/abacus_dump_master.sv
// Wishbone classic initiator that dumps a window of ABACUS counters onto a
// valid/ready stream. Define ABACUS_DUMP_TIMEOUT_EN to enable the ack timeout.
module abacus_dump_master
    import abacus_pkg::*;
#(
    parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf003_0000,
    parameter logic [31:0] FIRST_OFFSET     = ABACUS_OFS_FIRST_CNT,
    parameter int unsigned NUM_WORDS        = 11,
    parameter bit          CLEAR_AFTER_DUMP = 1'b0,
    parameter logic [31:0] CTRL_OFFSET      = ABACUS_OFS_ENABLE,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic [31:0] m_data,
    output logic [7:0]  m_index,
    output logic        m_valid,
    input  logic        m_ready
);

    if (NUM_WORDS < 1 || NUM_WORDS > 255) begin : g_bad_num_words
        $error("abacus_dump_master: NUM_WORDS must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("abacus_dump_master: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [31:0] CTRL_ADR = ABACUS_BASE_ADDR + CTRL_OFFSET;

    dump_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, mdata_q, mdata_d;
    logic        mvalid_q, mvalid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        bus_ack, bus_issue, tmo_expired, abort;

    // Ack only counts while our own strobe is up.
    assign bus_ack   = cyc_q & stb_q & wb_ack;
    assign bus_issue = !cyc_q && (state_q inside {ST_RD_REQ, ST_CLR_OFF, ST_CLR_ON});

`ifdef ABACUS_DUMP_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Loaded as the cycle starts, so cyc stays up for exactly TIMEOUT_CYCLES.
    abacus_wb_timeout #(.WIDTH(TW)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bus_issue),
        .en_i       (cyc_q & ~wb_ack),
        .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
        .expired_o  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_REQ;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (bus_issue) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    dat_d = '0;
                    adr_d = word_addr(ABACUS_BASE_ADDR, FIRST_OFFSET, idx_q);
                end else if (bus_ack) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    mdata_d  = wb_dat_i;
                    mvalid_d = 1'b1;
                    state_d  = ST_PUSH;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            ST_PUSH: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        if (CLEAR_AFTER_DUMP) begin
                            state_d = ST_CLR_OFF;
                        end else begin
                            state_d = ST_FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_CLR_OFF, ST_CLR_ON: begin
                if (bus_issue) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = CTRL_ADR;
                    dat_d = (state_q == ST_CLR_ON) ? 32'd1 : 32'd0;
                end else if (bus_ack) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    dat_d = '0;
                    if (state_q == ST_CLR_OFF) begin
                        state_d = ST_CLR_ON;
                    end else begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Timeout: abandon the rest of the dump, including any clear.
        if (abort) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            dat_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wb_cyc   = cyc_q;
    assign wb_stb   = stb_q;
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_dat_o = dat_q;
    assign m_data   = mdata_q;
    assign m_index  = idx_q;
    assign m_valid  = mvalid_q;

endmodule

// File: tb/tb_abacus_dump_master.sv
// Randomized bench for abacus_dump_master with a queue-based reference model.
// Runs the timeout scenario when ABACUS_DUMP_TIMEOUT_EN is defined.
module tb_abacus_dump_master;

    localparam logic [31:0] BASE = 32'hf003_0000;
    localparam int NW = 3;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_t;

    logic        clk, rst, start, busy, done, err;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i, m_data;
    logic [7:0]  m_index;
    logic        m_valid, m_ready;
    logic        ack_en, stray;
    logic [31:0] salt;

    int n_chk = 0, n_fail = 0;

    abacus_dump_master #(
        .ABACUS_BASE_ADDR (BASE),
        .FIRST_OFFSET     (32'h0000_000C),
        .NUM_WORDS        (NW),
        .CLEAR_AFTER_DUMP (1'b1),
        .CTRL_OFFSET      (32'h0000_0004),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
        .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-ack responder; read data is a salted function of address.
    assign wb_ack   = (wb_cyc & wb_stb & ack_en) | stray;
    assign wb_dat_i = wb_we ? 32'h0 : (wb_adr ^ salt);

    // Monitor samples on the falling edge, mid-cycle.
    bus_t        bus_log[$];
    logic [39:0] str_log[$];
    int ncyc = 0, done_cnt = 0, err_cnt = 0, errdone = 0, cyc_hi = 0, mv_cnt = 0;
    int last_evt = 0, done_at = 0, gap_bad = 0, hold_bad = 0;
    logic prev_ack = 0, prev_hold = 0;
    logic [39:0] prev_beat = '0;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (wb_cyc && wb_stb && wb_ack) begin
            bus_log.push_back({wb_adr, wb_we, wb_dat_o});
            last_evt <= ncyc;
        end
        if (m_valid && m_ready) begin
            str_log.push_back({m_index, m_data});
            last_evt <= ncyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= ncyc;
            if (err) errdone <= errdone + 1;
        end
        if (err)     err_cnt <= err_cnt + 1;
        if (wb_cyc)  cyc_hi  <= cyc_hi + 1;
        if (m_valid) mv_cnt  <= mv_cnt + 1;
        if (prev_ack && wb_cyc) gap_bad <= gap_bad + 1;
        if (rst && prev_hold && (!m_valid || {m_index, m_data} !== prev_beat))
            hold_bad <= hold_bad + 1;
        prev_ack  <= wb_cyc & wb_stb & wb_ack;
        prev_hold <= m_valid & ~m_ready;
        prev_beat <= {m_index, m_data};
    end

    // Reference model: NW reads walking up from the first counter, then a
    // 0-then-1 write to the enable register.
    bus_t        exp_bus[$];
    logic [39:0] exp_str[$];

    function automatic void build_exp(input logic [31:0] s);
        logic [31:0] a;
        exp_bus.delete();
        exp_str.delete();
        for (int i = 0; i < NW; i++) begin
            a = BASE + 32'h0000_000C + 32'(4 * i);
            exp_bus.push_back({a, 1'b0, 32'h0});
            exp_str.push_back({8'(i), a ^ s});
        end
        exp_bus.push_back({BASE + 32'h4, 1'b1, 32'h0});
        exp_bus.push_back({BASE + 32'h4, 1'b1, 32'h1});
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        n_chk++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", nm, k);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [139:0] outs;
        #1 outs = {busy, done, err, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, m_data, m_index, m_valid};
        n_chk++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_in: outputs %h exp 0", outs); end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 outs = {busy, done, err, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, m_data, m_index, m_valid};
        n_chk++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_idle: outputs %h exp 0", outs); end
    endtask

    task automatic test_basic();
        int b0 = bus_log.size(), s0 = str_log.size(), d0 = done_cnt, e0 = err_cnt, g0 = gap_bad;
        salt = $urandom; m_ready = 1'b1;
        build_exp(salt);
        pulse_start();
        n_chk++;
        if ({busy, wb_cyc} !== 2'b10) begin n_fail++; $display("FAIL basic_accept: busy,cyc %b exp 10", {busy, wb_cyc}); end
        @(posedge clk); #1;
        n_chk++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o} !== {3'b110, BASE + 32'hC, 32'h0}) begin
            n_fail++; $display("FAIL basic_req: cyc/stb/we/adr/dat %h exp %h",
                {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o}, {3'b110, BASE + 32'hC, 32'h0});
        end
        @(posedge clk); #1;
        n_chk++;
        if ({wb_cyc, m_valid, m_index, m_data} !== {2'b01, exp_str[0]}) begin
            n_fail++; $display("FAIL basic_capture: cyc/valid/idx/data %h exp %h",
                {wb_cyc, m_valid, m_index, m_data}, {2'b01, exp_str[0]});
        end
        wait_done("basic", d0);
        n_chk++;
        if (bus_log.size() - b0 != exp_bus.size()) begin n_fail++; $display("FAIL basic_bus_count: %0d exp %0d", bus_log.size() - b0, exp_bus.size()); end
        for (int i = 0; i < exp_bus.size(); i++) begin
            bus_t got = (b0 + i < bus_log.size()) ? bus_log[b0 + i] : '1;
            n_chk++;
            if (got !== exp_bus[i]) begin n_fail++; $display("FAIL basic_bus[%0d]: %h exp %h", i, got, exp_bus[i]); end
        end
        for (int i = 0; i < NW; i++) begin
            logic [39:0] got = (s0 + i < str_log.size()) ? str_log[s0 + i] : '1;
            n_chk++;
            if (got !== exp_str[i]) begin n_fail++; $display("FAIL basic_stream[%0d]: %h exp %h", i, got, exp_str[i]); end
        end
        n_chk++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin n_fail++; $display("FAIL basic_done_err: done %0d err %0d exp 1 0", done_cnt - d0, err_cnt - e0); end
        n_chk++;
        if (done_at != last_evt + 1) begin n_fail++; $display("FAIL basic_done_timing: done at %0d exp %0d", done_at, last_evt + 1); end
        n_chk++;
        if (gap_bad != g0) begin n_fail++; $display("FAIL basic_gap: %0d back-to-back cycles exp 0", gap_bad - g0); end
    endtask

    task automatic test_stall();
        int s0 = str_log.size(), d0 = done_cnt, k = 0, bad = 0;
        logic [31:0] hold;
        salt = $urandom; m_ready = 1'b1;
        build_exp(salt);
        pulse_start();
        while (!(m_valid && m_index == 8'd1) && k < 50) begin @(posedge clk); #1; k++; end
        m_ready = 1'b0;
        hold = m_data;
        repeat (20) begin
            @(posedge clk); #1;
            if (!m_valid || m_data !== hold || m_index !== 8'd1 || wb_cyc) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles exp 0", bad); end
        n_chk++;
        if (hold !== exp_str[1][31:0]) begin n_fail++; $display("FAIL stall_data: %h exp %h", hold, exp_str[1][31:0]); end
        m_ready = 1'b1;
        wait_done("stall", d0);
        for (int i = 0; i < NW; i++) begin
            logic [39:0] got = (s0 + i < str_log.size()) ? str_log[s0 + i] : '1;
            n_chk++;
            if (got !== exp_str[i]) begin n_fail++; $display("FAIL stall_stream[%0d]: %h exp %h", i, got, exp_str[i]); end
        end
    endtask

    task automatic test_random_ready();
        int h0 = hold_bad, g0 = gap_bad;
        for (int r = 0; r < 3; r++) begin
            int b0 = bus_log.size(), s0 = str_log.size(), d0 = done_cnt, k = 0;
            salt = $urandom;
            build_exp(salt);
            pulse_start();
            while (done_cnt == d0 && k < 300) begin @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1)); k++; end
            m_ready = 1'b1;
            wait_done("random", d0);
            n_chk++;
            if (bus_log.size() - b0 != exp_bus.size()) begin n_fail++; $display("FAIL random_bus_count: %0d exp %0d", bus_log.size() - b0, exp_bus.size()); end
            for (int i = 0; i < exp_bus.size(); i++) begin
                bus_t got = (b0 + i < bus_log.size()) ? bus_log[b0 + i] : '1;
                n_chk++;
                if (got !== exp_bus[i]) begin n_fail++; $display("FAIL random_bus[%0d]: %h exp %h", i, got, exp_bus[i]); end
            end
            for (int i = 0; i < NW; i++) begin
                logic [39:0] got = (s0 + i < str_log.size()) ? str_log[s0 + i] : '1;
                n_chk++;
                if (got !== exp_str[i]) begin n_fail++; $display("FAIL random_stream[%0d]: %h exp %h", i, got, exp_str[i]); end
            end
        end
        n_chk++;
        if (hold_bad != h0 || gap_bad != g0) begin n_fail++; $display("FAIL random_protocol: hold %0d gap %0d exp 0 0", hold_bad - h0, gap_bad - g0); end
    endtask

    task automatic test_busy_start_stray();
        int b0 = bus_log.size(), s0 = str_log.size(), d0 = done_cnt, k = 0;
        salt = $urandom;
        build_exp(salt);
        pulse_start();
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk); #1;
            stray   = 1'b0;
            start   = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy && !wb_cyc) stray = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            k++;
        end
        start = 1'b0; stray = 1'b0; m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_chk++;
        if (bus_log.size() - b0 != exp_bus.size() || str_log.size() - s0 != NW) begin
            n_fail++; $display("FAIL busy_counts: bus %0d words %0d exp %0d %0d",
                bus_log.size() - b0, str_log.size() - s0, exp_bus.size(), NW);
        end
        for (int i = 0; i < NW; i++) begin
            logic [39:0] got = (s0 + i < str_log.size()) ? str_log[s0 + i] : '1;
            n_chk++;
            if (got !== exp_str[i]) begin n_fail++; $display("FAIL busy_stream[%0d]: %h exp %h", i, got, exp_str[i]); end
        end
        n_chk++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_done: %0d pulses exp 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int b0, s0, d0 = done_cnt, k = 0;
        salt = $urandom; m_ready = 1'b1;
        pulse_start();
        while (!(wb_cyc && m_index == 8'd1) && k < 50) begin @(posedge clk); #1; k++; end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({wb_cyc, wb_stb, m_valid, busy, m_index} !== '0) begin
            n_fail++; $display("FAIL rstmid_async: cyc/stb/valid/busy/idx %h exp 0", {wb_cyc, wb_stb, m_valid, busy, m_index});
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL rstmid_no_done: %0d pulses exp 0", done_cnt - d0); end
        b0 = bus_log.size(); s0 = str_log.size(); d0 = done_cnt;
        salt = $urandom;
        build_exp(salt);
        pulse_start();
        wait_done("rstmid", d0);
        for (int i = 0; i < exp_bus.size(); i++) begin
            bus_t got = (b0 + i < bus_log.size()) ? bus_log[b0 + i] : '1;
            n_chk++;
            if (got !== exp_bus[i]) begin n_fail++; $display("FAIL rstmid_bus[%0d]: %h exp %h", i, got, exp_bus[i]); end
        end
        for (int i = 0; i < NW; i++) begin
            logic [39:0] got = (s0 + i < str_log.size()) ? str_log[s0 + i] : '1;
            n_chk++;
            if (got !== exp_str[i]) begin n_fail++; $display("FAIL rstmid_stream[%0d]: %h exp %h", i, got, exp_str[i]); end
        end
    endtask

`ifdef ABACUS_DUMP_TIMEOUT_EN
    task automatic test_timeout();
        int b0 = bus_log.size(), d0 = done_cnt, e0 = err_cnt, x0 = errdone, c0 = cyc_hi, v0 = mv_cnt;
        ack_en = 1'b0; m_ready = 1'b1;
        pulse_start();
        wait_done("timeout", d0);
        ack_en = 1'b1;
        n_chk++;
        if (cyc_hi - c0 != 8) begin n_fail++; $display("FAIL timeout_cyc_len: %0d cycles exp 8", cyc_hi - c0); end
        n_chk++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1 || errdone - x0 != 1) begin
            n_fail++; $display("FAIL timeout_pulses: done %0d err %0d together %0d exp 1 1 1", done_cnt - d0, err_cnt - e0, errdone - x0);
        end
        n_chk++;
        if (mv_cnt != v0 || bus_log.size() != b0 || busy) begin
            n_fail++; $display("FAIL timeout_abort: valid cycles %0d bus %0d busy %b exp 0 0 0", mv_cnt - v0, bus_log.size() - b0, busy);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; m_ready = 1'b1; ack_en = 1'b1; stray = 1'b0; salt = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_random_ready();
        test_busy_start_stray();
        test_reset_mid();
`ifdef ABACUS_DUMP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
